// File: rtl/mc_core.sv
// mc_core: multicycle MIPS-subset core with a unified memory port
// driven through a variable-latency request/ready handshake.
module mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] alu_result,
    output logic [3:0]  state_o,
    output logic        halted,
    output logic        illegal,
    output logic        mem_timeout
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_BRK  = 6'h0D;

    state_t      state;
    state_t      nxt;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] rf [32];
    logic [31:0] wait_cnt;
    logic        illegal_q;
    logic        timeout_q;

    logic [31:0] alu_res;
    logic        ill_set;
    logic        acc_ok;
    logic        to_hit;
    logic        is_r_alu;
    logic        is_brk;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};

    assign is_r_alu = (op == OP_R) &&
                      (funct == FN_ADD || funct == FN_SUB ||
                       funct == FN_AND || funct == FN_OR ||
                       funct == FN_SLT);
    assign is_brk   = (op == OP_R) && (funct == FN_BRK);

    // mem_req is masked by reset so nothing leaves the core while held
    assign mem_req   = reset &&
                       (state == FETCH || state == MEM_RD ||
                        state == MEM_WR);
    assign mem_we    = mem_req && (state == MEM_WR);
    assign mem_addr  = (state == FETCH) ? pc : alu_out;
    assign mem_wdata = b;

    assign acc_ok = mem_req && mem_ready;
    assign to_hit = (WAIT_MAX != 0) && mem_req && !mem_ready &&
                    (wait_cnt == WAIT_MAX);

    assign alu_result  = alu_res;
    assign state_o     = state;
    assign halted      = (state == HALT);
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;

    always_comb begin
        alu_res = pc + 32'd4;
        case (state)
            DECODE: alu_res = pc + (sext << 2);
            EXEC_R: begin
                case (funct)
                    FN_SUB:  alu_res = a - b;
                    FN_AND:  alu_res = a & b;
                    FN_OR:   alu_res = a | b;
                    FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
                    default: alu_res = a + b;
                endcase
            end
            EXEC_I, MEM_ADDR: alu_res = a + sext;
            BRANCH:           alu_res = a - b;
            default: ;
        endcase
    end

    always_comb begin
        nxt     = state;
        ill_set = 1'b0;
        case (state)
            FETCH: begin
                if (to_hit)
                    nxt = HALT;
                else if (mem_ready)
                    nxt = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    is_r_alu:      nxt = EXEC_R;
                    is_brk:        nxt = HALT;
                    op == OP_ADDI: nxt = EXEC_I;
                    op == OP_LW,
                    op == OP_SW:   nxt = MEM_ADDR;
                    op == OP_BEQ:  nxt = BRANCH;
                    op == OP_J:    nxt = JUMP;
                    default: begin
                        nxt     = HALT;
                        ill_set = 1'b1;
                    end
                endcase
            end
            EXEC_R:   nxt = WB_R;
            EXEC_I:   nxt = WB_I;
            MEM_ADDR: nxt = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (to_hit)
                    nxt = HALT;
                else if (mem_ready)
                    nxt = WB_MEM;
            end
            MEM_WR: begin
                if (to_hit)
                    nxt = HALT;
                else if (mem_ready)
                    nxt = FETCH;
            end
            WB_R, WB_I, WB_MEM: nxt = FETCH;
            BRANCH, JUMP:       nxt = FETCH;
            HALT:               nxt = HALT;
            default:            nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= nxt;
            if (ill_set)
                illegal_q <= 1'b1;
            if (to_hit)
                timeout_q <= 1'b1;
            // counts consecutive wait cycles of the pending access only
            if (mem_req && !mem_ready)
                wait_cnt <= wait_cnt + 32'd1;
            else
                wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (acc_ok) begin
                        ir <= mem_rdata;
                        pc <= alu_res;
                    end
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= alu_res;
                end
                EXEC_R, EXEC_I, MEM_ADDR: alu_out <= alu_res;
                MEM_RD: begin
                    if (acc_ok)
                        mdr <= mem_rdata;
                end
                BRANCH: begin
                    if (alu_res == 32'd0)
                        pc <= alu_out;
                end
                JUMP: pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // entry 0 is never written, so it always reads as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else begin
            case (state)
                WB_R: begin
                    if (rd != 5'd0)
                        rf[rd] <= alu_out;
                end
                WB_I: begin
                    if (rt != 5'd0)
                        rf[rt] <= alu_out;
                end
                WB_MEM: begin
                    if (rt != 5'd0)
                        rf[rt] <= mdr;
                end
                default: ;
            endcase
        end
    end

endmodule
